// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and control unit for the 5-stage MIPS pipeline.
//
// It tracks the in-flight instructions in EX, MEM and WB and drives the
// hold/clear enables of the stage registers.
//
// Ports
//   h_clk, h_rst                 clock (rising edge), asynchronous active-low reset
//   h_i_ce                       ID holds a valid instruction
//   h_i_rs/h_i_rt/h_i_rd         ID register addresses
//   h_i_use_rs/h_i_use_rt        ID instruction reads rs / rt
//   h_i_regwrite/h_i_memread     ID writes rd / is a load
//   h_i_branch_taken             EX resolved a taken branch or jump
//   h_i_mem_stall                data memory not ready
//   h_o_freeze                   all stage registers and PC hold
//   h_o_stall                    PC and IF/ID hold (load-use)
//   h_o_bubble                   ID/EX loads a NOP
//   h_o_flush                    IF/ID invalidated
//   h_o_fwd_a/h_o_fwd_b          EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   h_o_valid                    valid bits {WB, MEM, EX}
//   h_o_stall_cnt/h_o_flush_cnt  performance counters (HAZARD_PERF_EN only)
//
// Build option: define HAZARD_PERF_EN to add the saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_AWIDTH   = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  h_clk,
    input  logic                  h_rst,
    input  logic                  h_i_ce,
    input  logic [REG_AWIDTH-1:0] h_i_rs,
    input  logic [REG_AWIDTH-1:0] h_i_rt,
    input  logic                  h_i_use_rs,
    input  logic                  h_i_use_rt,
    input  logic [REG_AWIDTH-1:0] h_i_rd,
    input  logic                  h_i_regwrite,
    input  logic                  h_i_memread,
    input  logic                  h_i_branch_taken,
    input  logic                  h_i_mem_stall,
    output logic                  h_o_freeze,
    output logic                  h_o_stall,
    output logic                  h_o_bubble,
    output logic                  h_o_flush,
    output logic [1:0]            h_o_fwd_a,
    output logic [1:0]            h_o_fwd_b,
    output logic [2:0]            h_o_valid
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  h_o_stall_cnt,
    output logic [CNT_WIDTH-1:0]  h_o_flush_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [REG_AWIDTH-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } slot_t;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    // Only the fields that something downstream consumes are kept per slot:
    // MEM needs {valid, rd, regwrite} for forwarding, WB only its valid bit.
    slot_t                 ex_q, ex_d;
    logic                  mem_valid_q, mem_regwrite_q;
    logic [REG_AWIDTH-1:0] mem_rd_q;
    logic                  wb_valid_q;
    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    logic freeze, flush, stall, bubble, load_use, branch_start, hit_rs, hit_rt;

    function automatic logic [1:0] fwd_sel(
        input logic                  use_src,
        input logic [REG_AWIDTH-1:0] src,
        input slot_t                 ex,
        input logic                  mem_valid,
        input logic                  mem_regwrite,
        input logic [REG_AWIDTH-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && src != '0) begin
            if (ex.valid && ex.regwrite && ex.rd == src)
                sel = 2'b01;
            else if (mem_valid && mem_regwrite && mem_rd == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        hit_rs       = h_i_use_rs && (h_i_rs == ex_q.rd);
        hit_rt       = h_i_use_rt && (h_i_rt == ex_q.rd);
        load_use     = h_i_ce && ex_q.valid && ex_q.memread && (ex_q.rd != '0) && (hit_rs || hit_rt);
        branch_start = (state_q == ST_IDLE) && h_i_branch_taken && ex_q.valid;
        // Every combinational output is gated by h_rst so they read 0 in reset.
        freeze       = h_rst && h_i_mem_stall;
        flush        = h_rst && !freeze && ((state_q == ST_FLUSH) || branch_start);
        stall        = h_rst && !freeze && !flush && load_use;
        bubble       = flush || stall;
    end

    always_comb begin
        if (bubble) begin
            ex_d    = '0;
            fwd_a_d = 2'b00;
            fwd_b_d = 2'b00;
        end else begin
            ex_d.valid    = h_i_ce;
            ex_d.rd       = h_i_rd;
            ex_d.regwrite = h_i_regwrite && (h_i_rd != '0);
            ex_d.memread  = h_i_memread;
            fwd_a_d = fwd_sel(h_i_use_rs, h_i_rs, ex_q, mem_valid_q, mem_regwrite_q, mem_rd_q);
            fwd_b_d = fwd_sel(h_i_use_rt, h_i_rt, ex_q, mem_valid_q, mem_regwrite_q, mem_rd_q);
        end
    end

    // The transition cycle itself is the first flush cycle, so FLUSH lasts
    // FLUSH_CYCLES-1 cycles: leave when the counter is about to reach 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            case (state_q)
                ST_IDLE: begin
                    if (branch_start && FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 2'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    cnt_d = 2'(cnt_q - 2'd1);
                    if (cnt_q <= 2'd1)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            ex_q           <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            fwd_a_q        <= '0;
            fwd_b_q        <= '0;
        end else if (!freeze) begin
            ex_q           <= ex_d;
            mem_valid_q    <= ex_q.valid;
            mem_regwrite_q <= ex_q.regwrite;
            mem_rd_q       <= ex_q.rd;
            wb_valid_q     <= mem_valid_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
        end
    end

    assign h_o_freeze = freeze;
    assign h_o_stall  = stall;
    assign h_o_bubble = bubble;
    assign h_o_flush  = flush;
    assign h_o_fwd_a  = fwd_a_q;
    assign h_o_fwd_b  = fwd_b_q;
    assign h_o_valid  = {wb_valid_q, mem_valid_q, ex_q.valid};

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    // stall and flush are already forced low while frozen.
    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign h_o_stall_cnt = stall_cnt_q;
    assign h_o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int unsigned AW = 5;
    localparam int unsigned FC = 2;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce, use_rs, use_rt, regwrite, memread, br, ms;
    logic [AW-1:0] rs, rt, rd;
    logic          freeze, stall, bubble, flush;
    logic [1:0]    fwd_a, fwd_b;
    logic [2:0]    valid;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AWIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .h_clk(clk), .h_rst(rst), .h_i_ce(ce), .h_i_rs(rs), .h_i_rt(rt),
        .h_i_use_rs(use_rs), .h_i_use_rt(use_rt), .h_i_rd(rd),
        .h_i_regwrite(regwrite), .h_i_memread(memread),
        .h_i_branch_taken(br), .h_i_mem_stall(ms),
        .h_o_freeze(freeze), .h_o_stall(stall), .h_o_bubble(bubble), .h_o_flush(flush),
        .h_o_fwd_a(fwd_a), .h_o_fwd_b(fwd_b), .h_o_valid(valid)
`ifdef HAZARD_PERF_EN
        , .h_o_stall_cnt(stall_cnt), .h_o_flush_cnt(flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline slots as a plain array (0=EX, 1=MEM, 2=WB),
    // number of flush cycles still owed, registered forwarding selects.
    typedef struct { bit v; int rd; bit rw; bit mr; } ent_t;
    ent_t m[3];
    int   flush_left;
    int   efa, efb;
    int   scnt, fcnt;
    bit   e_frz, e_fl, e_st, e_bub, e_start;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
        flush_left = 0; efa = 0; efb = 0; scnt = 0; fcnt = 0;
    endtask

    function automatic int mfwd(bit u, int src);
        if (!u || src == 0) return 0;
        if (m[0].v && m[0].rw && m[0].rd == src) return 1;
        if (m[1].v && m[1].rw && m[1].rd == src) return 2;
        return 0;
    endfunction

    task automatic compare();
        bit lu;
        lu = ce && m[0].v && m[0].mr && m[0].rd != 0 &&
             ((use_rs && int'(rs) == m[0].rd) || (use_rt && int'(rt) == m[0].rd));
        e_frz   = ms;
        e_start = flush_left == 0 && br && m[0].v;
        e_fl    = !e_frz && (flush_left > 0 || e_start);
        e_st    = !e_frz && !e_fl && lu;
        e_bub   = e_fl || e_st;
        chk("freeze", 32'(freeze), 32'(e_frz));
        chk("flush",  32'(flush),  32'(e_fl));
        chk("stall",  32'(stall),  32'(e_st));
        chk("bubble", 32'(bubble), 32'(e_bub));
        chk("fwd_a",  32'(fwd_a),  32'(efa));
        chk("fwd_b",  32'(fwd_b),  32'(efb));
        chk("valid",  32'(valid),  32'({m[2].v, m[1].v, m[0].v}));
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(fcnt));
`endif
    endtask

    task automatic model_update();
        int na, nb;
        if (e_frz) return;
        na = e_bub ? 0 : mfwd(use_rs, int'(rs));
        nb = e_bub ? 0 : mfwd(use_rt, int'(rt));
        m[2] = m[1];
        m[1] = m[0];
        if (e_bub) m[0] = '{0, 0, 0, 0};
        else m[0] = '{ce, int'(rd), regwrite && rd != 0, memread};
        efa = na; efb = nb;
        if (flush_left > 0) flush_left--;
        else if (e_start) flush_left = FC - 1;
        if (e_st && scnt < (1 << CW) - 1) scnt++;
        if (e_fl && fcnt < (1 << CW) - 1) fcnt++;
    endtask

    task automatic step(input bit c, input int s, input int t, input bit us, input bit ut,
                        input int d, input bit w, input bit r, input bit b, input bit st);
        @(negedge clk);
        ce = c; rs = AW'(s); rt = AW'(t); use_rs = us; use_rt = ut;
        rd = AW'(d); regwrite = w; memread = r; br = b; ms = st;
        #1;
        compare();
        model_update();
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_inputs();
        ce = 0; rs = '0; rt = '0; use_rs = 0; use_rt = 0;
        rd = '0; regwrite = 0; memread = 0; br = 0; ms = 0;
    endtask

    initial begin
        rst = 1'b0;
        zero_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        // Combinational outputs must stay low during reset.
        ms = 1; br = 1; ce = 1;
        #1;
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_valid",  32'(valid),  32'd0);
        chk("rst_fwd_a",  32'(fwd_a),  32'd0);
        zero_inputs();
        @(negedge clk);
        rst = 1'b1;
        nop();

        // lw $2 ; add $3,$2,$4 : one stall cycle, then fwd_a=10
        step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        step(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);
        chk("lu_stall",  32'(stall),  32'd1);
        chk("lu_bubble", 32'(bubble), 32'd1);
        step(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);
        chk("lu_clear", 32'(stall), 32'd0);
        nop();
        chk("lu_fwd_a", 32'(fwd_a), 32'd2);
        chk("lu_fwd_b", 32'(fwd_b), 32'd0);
        repeat (3) nop();

        // add $2 ; sub $5,$2,$2
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 2, 2, 1, 1, 5, 1, 0, 0, 0);
        chk("alu_nostall", 32'(stall), 32'd0);
        nop();
        chk("alu_fwd_a", 32'(fwd_a), 32'd1);
        chk("alu_fwd_b", 32'(fwd_b), 32'd1);
        repeat (3) nop();

        // add $2 ; add $2 ; or $6,$2,$0 : nearer stage wins
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 2, 0, 1, 1, 6, 1, 0, 0, 0);
        nop();
        chk("near_fwd_a", 32'(fwd_a), 32'd1);
        chk("near_fwd_b", 32'(fwd_b), 32'd0);
        repeat (3) nop();

        // load to $0 ; reader of $0
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 7, 1, 0, 0, 0);
        chk("r0_nostall", 32'(stall), 32'd0);
        nop();
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        chk("r0_fwd_b", 32'(fwd_b), 32'd0);
        repeat (3) nop();

        // taken branch: flush for FC=2 cycles, EX bubbles behind it
        step(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        chk("br_flush0",  32'(flush),  32'd1);
        chk("br_bubble0", 32'(bubble), 32'd1);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        chk("br_flush1", 32'(flush),    32'd1);
        chk("br_exv1",   32'(valid[0]), 32'd0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        chk("br_flush2", 32'(flush),    32'd0);
        chk("br_exv2",   32'(valid[0]), 32'd0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        chk("br_exv3", 32'(valid[0]), 32'd1);

        // branch with a mem_stall inside the window
        step(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
        chk("brs_flush0", 32'(flush), 32'd1);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 1);
        chk("brs_freeze", 32'(freeze), 32'd1);
        chk("brs_frz_fl", 32'(flush),  32'd0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        chk("brs_flush1", 32'(flush), 32'd1);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        chk("brs_flush2", 32'(flush), 32'd0);
        repeat (3) nop();

        // async reset in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
        step(1, 2, 0, 1, 0, 3, 1, 0, 0, 0);
        chk("rs_stall_pre", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rs_stall",  32'(stall),  32'd0);
        chk("rs_bubble", 32'(bubble), 32'd0);
        chk("rs_valid",  32'(valid),  32'd0);
`ifdef HAZARD_PERF_EN
        chk("rs_scnt", 32'(stall_cnt), 32'd0);
        chk("rs_fcnt", 32'(flush_cnt), 32'd0);
`endif
        zero_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        nop();
        chk("rs_after_valid", 32'(valid), 32'd0);

        // randomized traffic on a small register set to provoke hits
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
